miner_core_sha_ctrl: RTL
========================

# miner_core_sha_ctrl

Sequencer directly upstream of `miner_core_sha`. It accepts 512-bit message chunks over a valid/ready handshake and drives the core's `chunk`, `fh`, `msa_en`, `comp_en` and `add_en` inputs with the fixed schedule/compression timing. It chains the core's `h` output back into `fh` for multi-chunk messages and presents the final 256-bit digest on a valid/ready output. The miner top level instantiates it once per SHA core.

## Interface
Parameters:
- `MSA_CYCLES`, 48: cycles allowed for message-schedule expansion (W16..W63).
- `COMP_CYCLES`, 64: cycles allowed for compression rounds.

Ports:
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `chunk_in`  in  [0:511]  next message chunk, already padded.
- `chunk_valid`  in  1  `chunk_in` and `chunk_last` are valid.
- `chunk_last`  in  1  this chunk ends the message.
- `chunk_ready`  out  1  controller can accept a chunk.
- `abort`  in  1  synchronous; drop the current message.
- `chunk`  out  [0:511]  to core; registered chunk.
- `fh`  out  [0:7][0:31]  to core; chaining value.
- `msa_en`, `comp_en`, `add_en`  out  1 each  to core; single-cycle strobes.
- `h`  in  [0:255]  from core; result of `add_en`.
- `digest`  out  [0:255]  final hash.
- `digest_valid`  out  1  `digest` holds the final hash.
- `digest_ready`  in  1  consumer takes the digest.
- `busy`  out  1  not in IDLE.

## Operation
- States: IDLE, MSA, SCHED, COMP, ROUNDS, ADD, HOLD, DONE.
- **IDLE:**
  - `chunk_ready`=1.
  - On `chunk_valid`: register `chunk_in` into `chunk`, register `chunk_last`, go to MSA.
  - If the `first` flag is set, load `fh` with the SHA-256 IV (6a09e667 … 5be0cd19).
- **MSA:** `msa_en`=1 for one cycle, clear the counter, go to SCHED.
- **SCHED:** run `MSA_CYCLES` cycles, then go to COMP.
- **COMP:** `comp_en`=1 for one cycle, go to ROUNDS.
- **ROUNDS:** run `COMP_CYCLES` cycles, then go to ADD.
- **ADD:** `add_en`=1 for one cycle, go to HOLD.
- **HOLD:** sample `h` at the end of the cycle.
  - If not last: `fh`←`h`, clear `first`, go to IDLE.
  - If last: `digest`←`h`, go to DONE.
- **DONE:**
  - `digest_valid`=1 and `digest` stable until `digest_ready`.
  - On `digest_ready`: set `first`, go to IDLE.
- **abort** in any state except IDLE: strobes low that cycle, go to IDLE, set `first`, `digest_valid`=0. `abort` in IDLE is ignored.
- At most one strobe is high in any cycle. `chunk` and `fh` are stable from MSA through HOLD.
- `chunk_ready` is low outside IDLE. A `chunk_valid` held high in any other state is not consumed.

## Timing
- Reset values: `chunk`=0, `fh`=IV, `digest`=0, all strobes=0, `digest_valid`=0, `chunk_ready`=1, `busy`=0, state IDLE, `first`=1.
- Chunk accepted at edge 0 (end of cycle 0):
  - `msa_en` high in cycle 1.
  - SCHED occupies cycles 2..49.
  - `comp_en` high in cycle 50.
  - ROUNDS occupies cycles 51..114.
  - `add_en` high in cycle 115.
  - HOLD in cycle 116.
  - `digest_valid` or `chunk_ready` rises in cycle 117.
- Per-chunk occupancy is 117 cycles, i.e. `MSA_CYCLES`+`COMP_CYCLES`+5.
- `digest_valid` & `digest_ready` in the same cycle: the digest is consumed and `chunk_ready`=1 the next cycle. No same-cycle turnaround.
- `n_rst` asserted mid-operation: all outputs return to reset values immediately.
- The counter width fits max(`MSA_CYCLES`,`COMP_CYCLES`) and compares against N-1. No wrap-around is ever exposed.

## Structure
- Package `miner_sha_pkg` holds:
  - the state enum `ctrl_state_t`;
  - the `SHA256_IV` constant (`logic [0:7][0:31]`);
  - the default `MSA_CYCLES`/`COMP_CYCLES` localparams.
- One sub-module, `flex_counter` (parameterised width, clear, count_enable, rollover_val, rollover_flag). It times the SCHED and ROUNDS states.

## Test plan
All scenarios run with the real `miner_core_sha` attached.
- **Single chunk:** "hello" chunk (68656c6c6f80…0028), `chunk_last`=1 → `digest` 2cf24dba5fb0a30e26e83b2ac5b9e29e1b161e5c1fa7425e73043362938b9824 with `digest_valid` in cycle 117.
- **Two chunks:** "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" padded into two chunks → 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1. Second chunk's `fh` equals first-chunk `h`.
- **Strobe timing:** check `msa_en`/`comp_en`/`add_en` each high exactly one cycle, at cycles 1/50/115. `chunk_ready`=0 throughout; an extra `chunk_valid` during ROUNDS is not consumed.
- **Backpressure:** hold `digest_ready`=0 for 20 cycles → `digest` and `digest_valid` stable. Release → IDLE next cycle. A following "hello" again uses the IV and gives the same digest.
- **Abort:** assert `abort` in ROUNDS of chunk 1 of 2 → IDLE, `busy`=0. Next "hello" gives the correct digest, proving the IV was restored.
- **Reset:** drop `n_rst` in SCHED → all outputs at reset values asynchronously. Resume normal operation after release.

Source files
------------

// File: rtl/miner_core_sha_ctrl_pkg.sv
// Shared types and constants for the SHA core sequencer.
package miner_sha_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MSA    = 3'd1,
    SCHED  = 3'd2,
    COMP   = 3'd3,
    ROUNDS = 3'd4,
    ADD    = 3'd5,
    HOLD   = 3'd6,
    DONE   = 3'd7
  } ctrl_state_t;

  localparam logic [0:7][0:31] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam int DEF_MSA_CYCLES  = 48;
  localparam int DEF_COMP_CYCLES = 64;

  // Counter width able to hold the largest terminal count (N-1).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/miner_core_sha_ctrl_flex_counter.sv
// Up-counter with synchronous clear; flags when the count equals rollover_val
// and restarts from zero on the following enabled cycle.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count;

  assign rollover_flag = (count == rollover_val);

  // Count register: clear wins, otherwise step or wrap to zero at the limit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= rollover_flag ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/miner_core_sha_ctrl.sv
// Sequencer feeding one miner_core_sha: accepts padded chunks, strobes the
// schedule/compression/add phases, chains h into fh and returns the digest.
module miner_core_sha_ctrl
  import miner_sha_pkg::*;
#(
  parameter int MSA_CYCLES  = DEF_MSA_CYCLES,
  parameter int COMP_CYCLES = DEF_COMP_CYCLES
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [0:511]     chunk_in,
  input  logic             chunk_valid,
  input  logic             chunk_last,
  output logic             chunk_ready,
  input  logic             abort,
  output logic [0:511]     chunk,
  output logic [0:7][0:31] fh,
  output logic             msa_en,
  output logic             comp_en,
  output logic             add_en,
  input  logic [0:255]     h,
  output logic [0:255]     digest,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic             busy
);

  localparam int CNT_W = cnt_width(MSA_CYCLES, COMP_CYCLES);
  localparam logic [CNT_W-1:0] MSA_LAST  = CNT_W'(MSA_CYCLES - 1);
  localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(COMP_CYCLES - 1);

  ctrl_state_t      state, next_state;
  logic             last;
  logic             first;
  logic             cnt_clear, cnt_en, cnt_done;
  logic [CNT_W-1:0] cnt_limit;
  logic             abort_act;

  // abort is only meaningful while a message is in flight
  assign abort_act    = abort && (state != IDLE);
  assign chunk_ready  = (state == IDLE);
  assign busy         = (state != IDLE);
  assign digest_valid = (state == DONE) && !abort;

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (cnt_limit),
    .rollover_flag(cnt_done)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state, core strobes and counter control.
  always_comb begin
    next_state = state;
    msa_en     = 1'b0;
    comp_en    = 1'b0;
    add_en     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    cnt_limit  = MSA_LAST;
    unique case (state)
      IDLE:   if (chunk_valid) next_state = MSA;
      MSA: begin
        msa_en     = 1'b1;
        cnt_clear  = 1'b1;
        next_state = SCHED;
      end
      SCHED: begin
        cnt_en = 1'b1;
        if (cnt_done) next_state = COMP;
      end
      COMP: begin
        comp_en    = 1'b1;
        cnt_clear  = 1'b1;
        next_state = ROUNDS;
      end
      ROUNDS: begin
        cnt_en    = 1'b1;
        cnt_limit = COMP_LAST;
        if (cnt_done) next_state = ADD;
      end
      ADD: begin
        add_en     = 1'b1;
        next_state = HOLD;
      end
      HOLD:   next_state = last ? DONE : IDLE;
      DONE:   if (digest_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort_act) begin
      next_state = IDLE;
      msa_en     = 1'b0;
      comp_en    = 1'b0;
      add_en     = 1'b0;
    end
  end

  // Chunk capture, chaining value, digest and message-start tracking.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chunk  <= '0;
      fh     <= SHA256_IV;
      digest <= '0;
      last   <= 1'b0;
      first  <= 1'b1;
    end else if (abort_act) begin
      first <= 1'b1;
    end else begin
      case (state)
        IDLE: if (chunk_valid) begin
          chunk <= chunk_in;
          last  <= chunk_last;
          if (first) fh <= SHA256_IV;
        end
        HOLD: if (last) begin
          digest <= h;
        end else begin
          fh    <= h;
          first <= 1'b0;
        end
        DONE: if (digest_ready) first <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
